// File: rtl/ifu_pkg.sv
// Shared state encoding and default parameters for the instruction fetch unit.
package ifu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } ifu_state_e;

    localparam int         IFU_ADDR_W     = 8;
    localparam int         IFU_INSTR_W    = 8;
    localparam int         IFU_DEPTH      = 256;
    localparam int         IFU_FIFO_DEPTH = 2;
    localparam logic [3:0] IFU_HALT_OP    = 4'b1111;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO; flush empties it in one cycle and head shows the oldest entry.
module ifu_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign head    = buf_q[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
    assign do_push = push && ((count != CNT_FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            buf_q[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable program memory, prefetch FIFO and an IDLE/LOAD/RUN/HALT FSM.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int         ADDR_W     = IFU_ADDR_W,
    parameter int         INSTR_W    = IFU_INSTR_W,
    parameter int         DEPTH      = IFU_DEPTH,
    parameter int         FIFO_DEPTH = IFU_FIFO_DEPTH,
    parameter logic [3:0] HALT_OP    = IFU_HALT_OP
) (
    input  logic               CLK,
    input  logic               CLB,
    input  logic               load_en,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               halted,
    output logic               busy,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0]        ST_IDLE   = IDLE;
    localparam logic [1:0]        ST_LOAD   = LOAD;
    localparam logic [1:0]        ST_RUN    = RUN;
    localparam logic [1:0]        ST_HALT   = HALT;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int                ENT_W     = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W:0]    FIFO_LIM  = (CNT_W + 1)'(FIFO_DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [1:0]         state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               rd_valid;
    logic [ADDR_W-1:0]  rd_pc;
    logic [INSTR_W-1:0] rd_data;
    logic [ENT_W-1:0]   head;
    logic [ADDR_W-1:0]  head_pc;
    logic [INSTR_W-1:0] head_data;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occ;
    logic               in_run;
    logic               handshake;
    logic               halt_hs;
    logic               redir;
    logic               flush;
    logic               issue;

    // instr_valid/instr_ready: a transfer happens on a rising edge where both are high; while
    // valid is high and ready is low, data and pc hold. Valid never drops without a transfer
    // except on redirect, halt or reset.
    assign in_run      = (state == ST_RUN);
    assign {head_pc, head_data} = head;
    assign instr_valid = in_run && !fifo_empty;
    assign instr_pc    = instr_valid ? head_pc : '0;
    assign instr_data  = instr_valid ? head_data : '0;
    assign handshake   = instr_valid && instr_ready;
    assign halt_hs     = handshake && (head_data[INSTR_W-1 -: 4] == HALT_OP);
    assign redir       = in_run && redirect_valid;
    assign flush       = halt_hs || redir;

    // Occupancy counts the entry leaving this cycle as gone so a full-rate stream never gaps.
    assign occ   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_valid} - {{CNT_W{1'b0}}, handshake};
    assign issue = in_run && !flush && (occ < FIFO_LIM);

    assign busy      = in_run;
    assign halted    = (state == ST_HALT);
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (!CLB && (state == ST_LOAD) && load_we && ({1'b0, load_addr} < DEPTH_LIM))
            mem[load_addr[IDX_W-1:0]] <= load_data;
        if (issue)
            rd_data <= mem[fetch_pc[IDX_W-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (CLB) begin
            state    <= ST_IDLE;
            fetch_pc <= '0;
            rd_valid <= 1'b0;
            rd_pc    <= '0;
        end else begin
            rd_valid <= issue;
            if (issue) begin
                rd_pc    <= fetch_pc;
                fetch_pc <= (fetch_pc == PC_LAST) ? '0 : fetch_pc + 1'b1;
            end
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (load_en) begin
                        state <= ST_LOAD;
                    end else if (start) begin
                        state    <= ST_RUN;
                        fetch_pc <= start_addr;
                    end
                end
                ST_LOAD: begin
                    if (!load_en)
                        state <= ST_IDLE;
                end
                ST_RUN: begin
                    if (halt_hs)
                        state <= ST_HALT;
                    else if (redir)
                        fetch_pc <= redirect_addr;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ifu_fifo #(
        .W     (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (CLB),
        .flush     (flush),
        .push      (rd_valid),
        .push_data ({rd_pc, rd_data}),
        .pop       (handshake),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );
endmodule
